// File: rtl/alu_pkg.sv
// Shared ALU definitions: default widths, opcode encodings and
// the packed flag bundle passed from the core into the result stage.
package alu_pkg;

   localparam int NB_DATA_DEF   = 8;
   localparam int NB_OPCODE_DEF = 6;

   localparam logic [5:0] OP_ADD = 6'b100000;
   localparam logic [5:0] OP_SUB = 6'b100010;
   localparam logic [5:0] OP_AND = 6'b100100;
   localparam logic [5:0] OP_OR  = 6'b100101;
   localparam logic [5:0] OP_XOR = 6'b100110;
   localparam logic [5:0] OP_NOR = 6'b100111;
   localparam logic [5:0] OP_SRA = 6'b000011;
   localparam logic [5:0] OP_SRL = 6'b000010;

   typedef struct packed {
      logic zero;
      logic negative;
      logic carry;
      logic overflow;
      logic err;
   } alu_flags_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: op_a, op_b, opcode -> result, flags.
// op_b is the unsigned shift amount for SRA/SRL.
module alu_core
   import alu_pkg::*;
#(
   parameter int NB_DATA   = NB_DATA_DEF,
   parameter int NB_OPCODE = NB_OPCODE_DEF
) (
   input  logic [NB_DATA-1:0]   op_a,
   input  logic [NB_DATA-1:0]   op_b,
   input  logic [NB_OPCODE-1:0] opcode,
   output logic [NB_DATA-1:0]   result,
   output alu_flags_t           flags
);

   localparam int M = NB_DATA - 1;
   localparam logic [NB_DATA-1:0] NB_L = NB_DATA[NB_DATA-1:0];

   localparam logic [NB_OPCODE-1:0] C_ADD = NB_OPCODE'(OP_ADD);
   localparam logic [NB_OPCODE-1:0] C_SUB = NB_OPCODE'(OP_SUB);
   localparam logic [NB_OPCODE-1:0] C_AND = NB_OPCODE'(OP_AND);
   localparam logic [NB_OPCODE-1:0] C_OR  = NB_OPCODE'(OP_OR);
   localparam logic [NB_OPCODE-1:0] C_XOR = NB_OPCODE'(OP_XOR);
   localparam logic [NB_OPCODE-1:0] C_NOR = NB_OPCODE'(OP_NOR);
   localparam logic [NB_OPCODE-1:0] C_SRA = NB_OPCODE'(OP_SRA);
   localparam logic [NB_OPCODE-1:0] C_SRL = NB_OPCODE'(OP_SRL);

   logic [NB_DATA:0]          sum;
   logic [NB_DATA:0]          dif;
   logic signed [NB_DATA-1:0] sra_s;
   logic [NB_DATA-1:0]        srl_u;
   logic                      big;

   always_comb begin
      sum   = {1'b0, op_a} + {1'b0, op_b};
      // top bit of the widened difference is the unsigned borrow
      dif   = {1'b0, op_a} - {1'b0, op_b};
      // kept in its own signed variable so the shift stays arithmetic
      sra_s = $signed(op_a) >>> op_b;
      srl_u = op_a >> op_b;
      big   = (op_b >= NB_L);

      result         = '0;
      flags          = '0;
      unique case (1'b1)
         (opcode == C_ADD): begin
            result         = sum[M:0];
            flags.carry    = sum[NB_DATA];
            flags.overflow = (op_a[M] == op_b[M])
                           && (sum[M] != op_a[M]);
         end
         (opcode == C_SUB): begin
            result         = dif[M:0];
            flags.carry    = dif[NB_DATA];
            flags.overflow = (op_a[M] != op_b[M])
                           && (dif[M] != op_a[M]);
         end
         (opcode == C_AND): result = op_a & op_b;
         (opcode == C_OR):  result = op_a | op_b;
         (opcode == C_XOR): result = op_a ^ op_b;
         (opcode == C_NOR): result = ~(op_a | op_b);
         (opcode == C_SRA): begin
            result = big ? {NB_DATA{op_a[M]}} : sra_s;
         end
         (opcode == C_SRL): begin
            result = big ? '0 : srl_u;
         end
         default: flags.err = 1'b1;
      endcase
      flags.zero     = (result == '0);
      flags.negative = result[M];
   end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU: S1 holds operands+opcode, S2 result+flags.
// Ports: i_clk, i_rst_n, i_valid/o_ready in, o_valid/i_ready out, flags.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int NB_DATA   = NB_DATA_DEF,
   parameter int NB_OPCODE = NB_OPCODE_DEF
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic [NB_DATA-1:0]   i_op_1,
   input  logic [NB_DATA-1:0]   i_op_2,
   input  logic [NB_OPCODE-1:0] i_opcode,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic [NB_DATA-1:0]   o_result,
   output logic                 o_zero,
   output logic                 o_negative,
   output logic                 o_carry,
   output logic                 o_overflow,
   output logic                 o_err
);

   logic                 s1_valid;
   logic [NB_DATA-1:0]   s1_a;
   logic [NB_DATA-1:0]   s1_b;
   logic [NB_OPCODE-1:0] s1_op;
   logic [NB_DATA-1:0]   core_res;
   alu_flags_t           core_flags;
   alu_flags_t           s2_flags;
   logic                 s2_adv;
   logic                 s1_adv;

   assign s2_adv  = !o_valid || i_ready;
   assign s1_adv  = !s1_valid || s2_adv;
   assign o_ready = s1_adv;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_op    <= '0;
      end else if (s1_adv) begin
         s1_valid <= i_valid;
         if (i_valid) begin
            s1_a  <= i_op_1;
            s1_b  <= i_op_2;
            s1_op <= i_opcode;
         end
      end
   end

   alu_core #(
      .NB_DATA   (NB_DATA),
      .NB_OPCODE (NB_OPCODE)
   ) u_core (
      .op_a   (s1_a),
      .op_b   (s1_b),
      .opcode (s1_op),
      .result (core_res),
      .flags  (core_flags)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_valid  <= 1'b0;
         o_result <= '0;
         s2_flags <= '0;
      end else if (s2_adv) begin
         o_valid <= s1_valid;
         if (s1_valid) begin
            o_result <= core_res;
            s2_flags <= core_flags;
         end
      end
   end

   assign o_zero     = s2_flags.zero;
   assign o_negative = s2_flags.negative;
   assign o_carry    = s2_flags.carry;
   assign o_overflow = s2_flags.overflow;
   assign o_err      = s2_flags.err;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: vector table, backpressure stream,
// and reset with operations in flight.
module tb_alu_pipe;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       i_valid = 1'b0;
   logic       o_ready;
   logic [7:0] i_op_1 = '0;
   logic [7:0] i_op_2 = '0;
   logic [5:0] i_opcode = '0;
   logic       o_valid;
   logic       i_ready = 1'b1;
   logic [7:0] o_result;
   logic       o_zero, o_negative, o_carry, o_overflow, o_err;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   alu_pipe #(.NB_DATA(8), .NB_OPCODE(6)) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_valid    (i_valid),
      .o_ready    (o_ready),
      .i_op_1     (i_op_1),
      .i_op_2     (i_op_2),
      .i_opcode   (i_opcode),
      .o_valid    (o_valid),
      .i_ready    (i_ready),
      .o_result   (o_result),
      .o_zero     (o_zero),
      .o_negative (o_negative),
      .o_carry    (o_carry),
      .o_overflow (o_overflow),
      .o_err      (o_err)
   );

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [5:0] op;
      logic [7:0] res;
      logic [4:0] fl;
   } vec_t;

   vec_t vecs[16];

   function automatic logic [4:0] flags_now();
      return {o_zero, o_negative, o_carry, o_overflow, o_err};
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                         input logic [5:0] op,
                         output logic [7:0] res,
                         output logic [4:0] fl, output int lat);
      @(posedge clk); #1;
      i_ready  = 1'b1;
      i_valid  = 1'b1;
      i_op_1   = a;
      i_op_2   = b;
      i_opcode = op;
      @(posedge clk); #1;
      i_valid = 1'b0;
      lat = 1;
      while (!o_valid && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      res = o_result;
      fl  = flags_now();
   endtask

   task automatic stream(input int hold);
      logic [7:0] sa[4];
      logic [7:0] sb[4];
      logic [5:0] so[4];
      logic [7:0] se[4];
      int k = 0;
      int n = 0;
      logic acc, take;
      sa = '{8'h01, 8'h03, 8'h10, 8'h0F};
      sb = '{8'h02, 8'h04, 8'h01, 8'hF0};
      so = '{6'b100000, 6'b100000, 6'b100010, 6'b100110};
      se = '{8'h03, 8'h07, 8'h0F, 8'hFF};
      for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
         i_ready = (cyc >= hold);
         i_valid = (k < 4);
         if (k < 4) begin
            i_op_1   = sa[k];
            i_op_2   = sb[k];
            i_opcode = so[k];
         end
         #1;
         if (hold > 0 && cyc == hold - 1) begin
            chk("bp_accepted", k, 2);
            chk("bp_o_ready", {31'd0, o_ready}, 0);
            chk("bp_o_valid", {31'd0, o_valid}, 1);
         end
         if (cyc < hold && o_valid)
            chk("bp_hold", {24'd0, o_result}, {24'd0, se[0]});
         if (hold == 0 && cyc == 4)
            chk("thru_accepted", k, 4);
         acc  = i_valid && o_ready;
         take = o_valid && i_ready;
         if (take) begin
            chk($sformatf("order_%0d_%0d", hold, n),
                {24'd0, o_result}, {24'd0, se[n]});
            n++;
         end
         @(posedge clk);
         if (acc) k++;
         #1;
      end
      i_valid = 1'b0;
      chk($sformatf("stream_count_%0d", hold), n, 4);
   endtask

   logic [7:0] r;
   logic [4:0] f;
   int lat;

   initial begin
      // {a, b, op, result, {zero,neg,carry,ovf,err}}
      vecs[0]  = '{8'h7F, 8'h01, 6'b100000, 8'h80, 5'b01010};
      vecs[1]  = '{8'h00, 8'h01, 6'b100010, 8'hFF, 5'b01100};
      vecs[2]  = '{8'hFF, 8'h01, 6'b100000, 8'h00, 5'b10100};
      vecs[3]  = '{8'h80, 8'h03, 6'b000011, 8'hF0, 5'b01000};
      vecs[4]  = '{8'h80, 8'h03, 6'b000010, 8'h10, 5'b00000};
      vecs[5]  = '{8'h80, 8'h09, 6'b000011, 8'hFF, 5'b01000};
      vecs[6]  = '{8'h80, 8'h09, 6'b000010, 8'h00, 5'b10000};
      vecs[7]  = '{8'h12, 8'h34, 6'b111111, 8'h00, 5'b10001};
      vecs[8]  = '{8'hF0, 8'h3C, 6'b100100, 8'h30, 5'b00000};
      vecs[9]  = '{8'hF0, 8'h0F, 6'b100101, 8'hFF, 5'b01000};
      vecs[10] = '{8'hAA, 8'hFF, 6'b100110, 8'h55, 5'b00000};
      vecs[11] = '{8'h00, 8'h00, 6'b100111, 8'hFF, 5'b01000};
      vecs[12] = '{8'h80, 8'h01, 6'b100010, 8'h7F, 5'b00010};
      vecs[13] = '{8'hC0, 8'h08, 6'b000011, 8'hFF, 5'b01000};
      vecs[14] = '{8'hFF, 8'h07, 6'b000010, 8'h01, 5'b00000};
      vecs[15] = '{8'h80, 8'h80, 6'b100000, 8'h00, 5'b10110};

      #3 rst_n = 1'b0;
      #9;
      chk("rst_o_valid", {31'd0, o_valid}, 0);
      chk("rst_result", {24'd0, o_result}, 0);
      chk("rst_flags", {27'd0, flags_now()}, 0);
      chk("rst_o_ready", {31'd0, o_ready}, 1);
      #11 rst_n = 1'b1;

      for (int i = 0; i < 16; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].op, r, f, lat);
         chk($sformatf("v%0d_res", i), {24'd0, r}, {24'd0, vecs[i].res});
         chk($sformatf("v%0d_flags", i), {27'd0, f}, {27'd0, vecs[i].fl});
         chk($sformatf("v%0d_lat", i), lat, 2);
      end

      @(posedge clk); #1;
      stream(4);
      @(posedge clk); #1;
      stream(0);

      // two ops in flight, output stalled, then reset
      @(posedge clk); #1;
      i_ready  = 1'b0;
      i_valid  = 1'b1;
      i_op_1   = 8'h05;
      i_op_2   = 8'h06;
      i_opcode = 6'b100000;
      @(posedge clk); #1;
      i_op_1 = 8'h21;
      i_op_2 = 8'h01;
      @(posedge clk); #1;
      i_valid = 1'b0;
      chk("flight_o_valid", {31'd0, o_valid}, 1);
      chk("flight_result", {24'd0, o_result}, 8'h0B);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_o_valid", {31'd0, o_valid}, 0);
      chk("arst_result", {24'd0, o_result}, 0);
      chk("arst_flags", {27'd0, flags_now()}, 0);
      @(posedge clk); @(posedge clk); #5;
      rst_n   = 1'b1;
      i_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         chk($sformatf("stale_%0d", c), {31'd0, o_valid}, 0);
      end
      chk("post_rst_ready", {31'd0, o_ready}, 1);
      run_op(8'h7F, 8'h01, 6'b100000, r, f, lat);
      chk("post_rst_res", {24'd0, r}, 8'h80);
      chk("post_rst_flags", {27'd0, f}, 5'b01010);
      chk("post_rst_lat", lat, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
